// File: rtl/reg_decode_gen_pkg.sv
// Shared definitions for reg_decode_gen: converter states, ASCII codes,
// the 10-entry volts/div gear label table and small helper functions.
package reg_decode_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_STORE = 2'd3
   } conv_state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam int BCD_MAX_DIGITS = 10;
   localparam int DABBLE_CYCLES  = 32;

   // 9-character labels, 1-2-5 sequence from 5 mV/div up to 5 V/div
   localparam logic [71:0] GEAR_LABEL [10] = '{
      "  5mV/div", " 10mV/div", " 20mV/div", " 50mV/div", "100mV/div",
      "200mV/div", "500mV/div", "   1V/div", "   2V/div", "   5V/div"
   };

   function automatic logic [71:0] gear_label(input logic [3:0] code);
      logic [71:0] lbl;
      if (code > 4'd9) begin
         lbl = GEAR_LABEL[0];
      end else begin
         lbl = GEAR_LABEL[int'(code)];
      end
      return lbl;
   endfunction

   function automatic logic [7:0] ascii_digit(input logic [3:0] d);
      return ASCII_ZERO + {4'h0, d};
   endfunction

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_decode_gen_bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to DIGITS BCD digits in 32 shift cycles.
// done is high during the final shift cycle, so bcd is valid from the next cycle on.
module bin2bcd_seq
#(
   parameter int DIGITS = 8
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [31:0]           din,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd
);
   import reg_decode_gen_pkg::*;

   localparam int BCD_W = BCD_MAX_DIGITS * 4;
   localparam int SR_W  = BCD_W + 32;
   localparam logic [4:0] CNT_LAST    = 5'(DABBLE_CYCLES - 1);
   localparam logic [4:0] CNT_LAST_M1 = 5'(DABBLE_CYCLES - 2);

   logic [SR_W-1:0] sr_r;
   logic [SR_W-1:0] adj_s;
   logic [4:0]      cnt_r;
   logic            run_r;
   logic            done_r;

   // add-3 correction on every BCD nibble before the shift
   always_comb begin
      adj_s = sr_r;
      for (int j = 0; j < BCD_MAX_DIGITS; j++) begin
         if (sr_r[32+4*j +: 4] >= 4'd5) begin
            adj_s[32+4*j +: 4] = sr_r[32+4*j +: 4] + 4'd3;
         end else begin
            adj_s[32+4*j +: 4] = sr_r[32+4*j +: 4];
         end
      end
   end

   // shift register, cycle counter and completion flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_r   <= {SR_W{1'b0}};
         cnt_r  <= 5'd0;
         run_r  <= 1'b0;
         done_r <= 1'b0;
      end else if (start) begin
         sr_r   <= {{BCD_W{1'b0}}, din};
         cnt_r  <= 5'd0;
         run_r  <= 1'b1;
         done_r <= 1'b0;
      end else if (run_r) begin
         sr_r   <= adj_s << 1'b1;
         cnt_r  <= cnt_r + 5'd1;
         done_r <= (cnt_r == CNT_LAST_M1);
         run_r  <= (cnt_r != CNT_LAST);
      end else begin
         done_r <= 1'b0;
      end
   end

   assign done = done_r;
   assign bcd  = sr_r[32 +: DIGITS*4];

endmodule

// File: rtl/reg_decode_gen.sv
// Register bank with shadow/active commit, gear decode and round-robin decimal
// field display. Define REG_DECODE_GEN_LZB_EN to blank leading zeros.
module reg_decode_gen
#(
   parameter int NCH        = 2,
   parameter int NREG       = 32,
   parameter int NFIELD     = 4,
   parameter int DIGITS     = 8,
   parameter int CH_BASE    = 2,
   parameter int FIELD_BASE = 16,
   parameter int AW         = $clog2(NREG)
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [AW-1:0]                wr_addr,
   input  logic [15:0]                  wr_data,
   input  logic                         commit,
   input  logic [31:0]                  ext_val,
   output logic [NREG*16-1:0]           active_regs,
   output logic [NCH*4-1:0]             ch_gear,
   output logic [NCH*80-1:0]            ch_gear_str,
   output logic [NCH-1:0]               gear_err,
   output logic [NFIELD*DIGITS*8-1:0]   dis_field,
   output logic [NFIELD-1:0]            field_valid,
   output logic                         busy,
   output logic                         upd
);
   import reg_decode_gen_pkg::*;

   localparam int FW    = (NFIELD > 1) ? $clog2(NFIELD) : 1;
   localparam int FLD_W = DIGITS * 8;
   localparam logic [FW-1:0] FIELD_LAST = FW'(NFIELD - 1);
   localparam logic [63:0]   SAT_LIMIT  = pow10(DIGITS);

   logic [15:0]               shadow_r [NREG];
   logic [15:0]               active_r [NREG];
   logic [NCH*4-1:0]          gear_r;
   logic [NCH*80-1:0]         gear_str_r;
   logic [NCH-1:0]            gear_err_r;
   logic                      upd_r;
   logic                      wr_hit_s;

   conv_state_t               state_r;
   conv_state_t               state_nx_s;
   logic [FW-1:0]             fidx_r;
   logic [FW-1:0]             fidx_nx_s;
   logic                      busy_r;
   logic                      sat_r;
   logic [31:0]               src_s;
   logic                      bcd_start_s;
   logic                      bcd_done_s;
   logic [DIGITS*4-1:0]       bcd_s;
   logic [FLD_W-1:0]          txt_s;
   logic [NFIELD*FLD_W-1:0]   dis_field_r;
   logic [NFIELD-1:0]         field_valid_r;

   assign wr_hit_s = wr_en && (32'(wr_addr) < 32'(NREG));

   // shadow bank: SPI writes land here first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) shadow_r[i] <= 16'h0000;
      end else if (wr_hit_s) begin
         shadow_r[wr_addr] <= wr_data;
      end
   end

   // active bank and gear decode; commit samples the pre-write shadow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) active_r[i] <= 16'h0000;
         for (int i = 0; i < NCH; i++) begin
            gear_str_r[80*i +: 80] <= {8'(16 + i), GEAR_LABEL[0]};
         end
         gear_r     <= {(NCH*4){1'b0}};
         gear_err_r <= {NCH{1'b0}};
         upd_r      <= 1'b0;
      end else begin
         upd_r <= commit;
         if (commit) begin
            for (int i = 0; i < NREG; i++) active_r[i] <= shadow_r[i];
            for (int i = 0; i < NCH; i++) begin
               gear_r[4*i +: 4]       <= shadow_r[CH_BASE+i][3:0];
               gear_err_r[i]          <= (shadow_r[CH_BASE+i][3:0] > 4'd9);
               gear_str_r[80*i +: 80] <= {8'(16 + i), gear_label(shadow_r[CH_BASE+i][3:0])};
            end
         end
      end
   end

   // converter state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         fidx_r  <= {FW{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         fidx_r  <= fidx_nx_s;
         busy_r  <= (state_nx_s != ST_IDLE);
      end
   end

   // converter next-state: endless round-robin over the fields
   always_comb begin
      state_nx_s  = state_r;
      fidx_nx_s   = fidx_r;
      bcd_start_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            state_nx_s = ST_LOAD;
         end
         ST_LOAD: begin
            bcd_start_s = 1'b1;
            state_nx_s  = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bcd_done_s) begin
               state_nx_s = ST_STORE;
            end else begin
               state_nx_s = ST_SHIFT;
            end
         end
         ST_STORE: begin
            state_nx_s = ST_LOAD;
            if (fidx_r == FIELD_LAST) begin
               fidx_nx_s = {FW{1'b0}};
            end else begin
               fidx_nx_s = fidx_r + FW'(1);
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            fidx_nx_s  = {FW{1'b0}};
         end
      endcase
   end

   // source select: field 0 is the measured frequency, others come from registers
   always_comb begin
      src_s = ext_val;
      for (int k = 1; k < NFIELD; k++) begin
         if (int'(fidx_r) == k) begin
            src_s = {16'h0000, active_r[FIELD_BASE+k-1]};
         end else begin
            src_s = src_s;
         end
      end
   end

   // saturation flag captured together with the converter snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_r <= 1'b0;
      end else if (state_r == ST_LOAD) begin
         sat_r <= ({32'h0000_0000, src_s} >= SAT_LIMIT);
      end
   end

   bin2bcd_seq #(
      .DIGITS (DIGITS)
   ) u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (bcd_start_s),
      .din   (src_s),
      .done  (bcd_done_s),
      .bcd   (bcd_s)
   );

   // BCD to ASCII text, most significant digit at the top of the slice
   always_comb begin : fmt_blk
`ifdef REG_DECODE_GEN_LZB_EN
      logic lead_v;
      lead_v = 1'b1;
`endif
      txt_s = {FLD_W{1'b0}};
      for (int j = DIGITS - 1; j >= 0; j--) begin
         if (sat_r) begin
            txt_s[8*j +: 8] = ASCII_NINE;
         end else begin
`ifdef REG_DECODE_GEN_LZB_EN
            if (lead_v && (bcd_s[4*j +: 4] == 4'd0) && (j != 0)) begin
               txt_s[8*j +: 8] = ASCII_SPACE;
            end else begin
               txt_s[8*j +: 8] = ascii_digit(bcd_s[4*j +: 4]);
               lead_v = 1'b0;
            end
`else
            txt_s[8*j +: 8] = ascii_digit(bcd_s[4*j +: 4]);
`endif
         end
      end
   end

   // display slices change only in STORE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dis_field_r   <= {(NFIELD*DIGITS){ASCII_ZERO}};
         field_valid_r <= {NFIELD{1'b0}};
      end else if (state_r == ST_STORE) begin
         for (int k = 0; k < NFIELD; k++) begin
            if (int'(fidx_r) == k) begin
               dis_field_r[FLD_W*k +: FLD_W] <= txt_s;
               field_valid_r[k]              <= 1'b1;
            end
         end
      end
   end

   // flatten the active bank onto the output bus
   always_comb begin
      active_regs = {(NREG*16){1'b0}};
      for (int i = 0; i < NREG; i++) begin
         active_regs[16*i +: 16] = active_r[i];
      end
   end

   assign ch_gear     = gear_r;
   assign ch_gear_str = gear_str_r;
   assign gear_err    = gear_err_r;
   assign dis_field   = dis_field_r;
   assign field_valid = field_valid_r;
   assign busy        = busy_r;
   assign upd         = upd_r;

endmodule

// File: tb/tb_reg_decode_gen.sv
// Self-checking bench for reg_decode_gen with a cycle-count based reference model.
module tb_reg_decode_gen;

   localparam int NCH = 2, NREG = 32, NFIELD = 4, DIGITS = 8;
   localparam int CH_BASE = 2, FIELD_BASE = 16, AW = 5;
   localparam int FLD_W = DIGITS * 8;
   localparam int CONV = 34;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic                        wr_en = 1'b0;
   logic [AW-1:0]               wr_addr = '0;
   logic [15:0]                 wr_data = '0;
   logic                        commit = 1'b0;
   logic [31:0]                 ext_val = '0;
   logic [NREG*16-1:0]          active_regs;
   logic [NCH*4-1:0]            ch_gear;
   logic [NCH*80-1:0]           ch_gear_str;
   logic [NCH-1:0]              gear_err;
   logic [NFIELD*FLD_W-1:0]     dis_field;
   logic [NFIELD-1:0]           field_valid;
   logic                        busy;
   logic                        upd;

   int checks = 0;
   int failures = 0;

   int                      cyc;
   logic [15:0]             m_sh [NREG];
   logic [15:0]             m_act [NREG];
   logic [31:0]             m_snap;
   logic [NFIELD*FLD_W-1:0] exp_dis;
   logic [NFIELD-1:0]       exp_fv;
   logic                    exp_upd;

   string gear_txt [10] = '{"  5mV/div", " 10mV/div", " 20mV/div", " 50mV/div", "100mV/div",
                            "200mV/div", "500mV/div", "   1V/div", "   2V/div", "   5V/div"};

   reg_decode_gen dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .ext_val(ext_val), .active_regs(active_regs), .ch_gear(ch_gear),
      .ch_gear_str(ch_gear_str), .gear_err(gear_err), .dis_field(dis_field),
      .field_valid(field_valid), .busy(busy), .upd(upd)
   );

   always #5 clk = ~clk;

   function automatic logic [FLD_W-1:0] fmt_field(input logic [31:0] v);
      logic [FLD_W-1:0] s;
      longint x, lim;
      x = longint'(v);
      lim = 1;
      for (int i = 0; i < DIGITS; i++) lim = lim * 10;
      if (x >= lim) begin
         for (int j = 0; j < DIGITS; j++) s[8*j +: 8] = 8'h39;
      end else begin
         for (int j = 0; j < DIGITS; j++) begin
            s[8*j +: 8] = 8'(48 + int'(x % 10));
            x = x / 10;
         end
`ifdef REG_DECODE_GEN_LZB_EN
         for (int j = DIGITS - 1; j >= 1; j--) begin
            if (s[8*j +: 8] != 8'h30) break;
            s[8*j +: 8] = 8'h20;
         end
`endif
      end
      return s;
   endfunction

   function automatic logic [79:0] gear_exp(input int ch, input logic [3:0] code);
      logic [79:0] r;
      int idx;
      idx = (code > 4'd9) ? 0 : int'(code);
      r[79:72] = 8'(16 + ch);
      for (int c = 0; c < 9; c++) r[8*(8-c) +: 8] = gear_txt[idx][c];
      return r;
   endfunction

   function automatic logic [FLD_W-1:0] fld(input logic [NFIELD*FLD_W-1:0] v, input int k);
      return v[k*FLD_W +: FLD_W];
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < NREG; i++) begin
         m_sh[i] = 16'h0;
         m_act[i] = 16'h0;
      end
      m_snap = 32'h0;
      exp_dis = {(NFIELD*DIGITS){8'h30}};
      exp_fv = '0;
      exp_upd = 1'b0;
   endtask

   // one clock: conversions follow a fixed 34-cycle cadence from reset release
   task automatic step();
      int p, m;
      @(posedge clk);
      cyc++;
      p = (cyc - 1) % CONV;
      m = (cyc - 1) / CONV;
      if (p == 0 && m >= 1) begin
         exp_dis[((m-1) % NFIELD)*FLD_W +: FLD_W] = fmt_field(m_snap);
         exp_fv[(m-1) % NFIELD] = 1'b1;
      end
      if (p == 1) begin
         if (m % NFIELD == 0) m_snap = ext_val;
         else m_snap = {16'h0, m_act[FIELD_BASE + (m % NFIELD) - 1]};
      end
      exp_upd = commit;
      if (commit) for (int i = 0; i < NREG; i++) m_act[i] = m_sh[i];
      if (wr_en && int'(wr_addr) < NREG) m_sh[wr_addr] = wr_data;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (dis_field !== {(NFIELD*DIGITS){8'h30}}) begin failures++; $display("FAIL reset_dis got=%h exp=all 30", dis_field); end
      checks++; if (field_valid !== 4'b0000) begin failures++; $display("FAIL reset_fv got=%b exp=0", field_valid); end
      checks++; if (upd !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_upd_busy got=%b%b exp=00", upd, busy); end
      checks++; if (active_regs !== '0) begin failures++; $display("FAIL reset_active got=%h exp=0", active_regs); end
      checks++; if (ch_gear !== 8'h00 || gear_err !== 2'b00) begin failures++; $display("FAIL reset_gear got=%h/%b exp=0", ch_gear, gear_err); end
      checks++; if (ch_gear_str !== {gear_exp(1, 4'd0), gear_exp(0, 4'd0)}) begin failures++; $display("FAIL reset_gear_str got=%h", ch_gear_str); end
      rst_n = 1'b1;
      step();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_release got=%b exp=1", busy); end
   endtask

   task automatic test_field1();
      int upd_cnt = 0;
      logic [FLD_W-1:0] want;
`ifdef REG_DECODE_GEN_LZB_EN
      want = "    1234";
`else
      want = "00001234";
`endif
      wr_en = 1'b1; wr_addr = 5'd16; wr_data = 16'd1234; step(); wr_en = 1'b0;
      commit = 1'b1; step(); commit = 1'b0;
      for (int n = 0; n < 2*NFIELD*CONV; n++) begin
         if (upd === 1'b1) upd_cnt++;
         step();
      end
      checks++; if (fld(dis_field, 1) !== want) begin failures++; $display("FAIL field1_1234 got=%s exp=%s", fld(dis_field, 1), want); end
      checks++; if (field_valid[1] !== 1'b1) begin failures++; $display("FAIL field1_valid got=%b exp=1", field_valid[1]); end
      checks++; if (upd_cnt != 1) begin failures++; $display("FAIL upd_once got=%0d exp=1", upd_cnt); end
      checks++; if (dis_field !== exp_dis) begin failures++; $display("FAIL field1_model got=%h exp=%h", dis_field, exp_dis); end
   endtask

   task automatic test_saturation();
      logic [31:0] vals [3] = '{32'd100000000, 32'd99999998, 32'hFFFF_FFFF};
      logic [FLD_W-1:0] nines;
      nines = "99999999";
      foreach (vals[i]) begin
         ext_val = vals[i];
         repeat (2*NFIELD*CONV) step();
         checks++; if (fld(dis_field, 0) !== fmt_field(vals[i])) begin failures++; $display("FAIL sat_field0 got=%s exp=%s", fld(dis_field, 0), fmt_field(vals[i])); end
         if (i == 0) begin
            checks++; if (fld(dis_field, 0) !== nines) begin failures++; $display("FAIL sat_1e8 got=%s exp=%s", fld(dis_field, 0), nines); end
         end
      end
   endtask

   task automatic test_gear_same_cycle();
      logic [3:0] code;
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 16'd3; step(); wr_en = 1'b0;
      commit = 1'b1; step(); commit = 1'b0; step();
      checks++; if (ch_gear[3:0] !== 4'd3) begin failures++; $display("FAIL gear_setup got=%0d exp=3", ch_gear[3:0]); end
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 16'd10; commit = 1'b1; step();
      wr_en = 1'b0; commit = 1'b0; step();
      checks++; if (ch_gear[3:0] !== 4'd3 || gear_err[0] !== 1'b0) begin failures++; $display("FAIL gear_same_cycle got=%0d/%b exp=3/0", ch_gear[3:0], gear_err[0]); end
      commit = 1'b1; step(); commit = 1'b0; step();
      checks++; if (ch_gear[3:0] !== 4'd10 || gear_err[0] !== 1'b1) begin failures++; $display("FAIL gear_second_commit got=%0d/%b exp=10/1", ch_gear[3:0], gear_err[0]); end
      checks++; if (ch_gear_str[79:0] !== gear_exp(0, 4'd10)) begin failures++; $display("FAIL gear_err_label got=%h exp=%h", ch_gear_str[79:0], gear_exp(0, 4'd10)); end
      for (int n = 0; n < 8; n++) begin
         code = 4'($urandom_range(0, 15));
         wr_en = 1'b1; wr_addr = 5'd3; wr_data = {12'($urandom), code}; step(); wr_en = 1'b0;
         commit = 1'b1; step(); commit = 1'b0; step();
         checks++;
         if (ch_gear[7:4] !== code || gear_err[1] !== (code > 4'd9) || ch_gear_str[159:80] !== gear_exp(1, code)) begin
            failures++; $display("FAIL gear_ch1 code=%0d got=%0d/%b/%h exp=%h", code, ch_gear[7:4], gear_err[1], ch_gear_str[159:80], gear_exp(1, code));
         end
      end
   endtask

   task automatic test_mid_shift();
      logic [15:0] a, b;
      bit found;
      a = 16'($urandom_range(0, 30000));
      b = a + 16'd777;
      wr_en = 1'b1; wr_addr = 5'd16; wr_data = a; step(); wr_en = 1'b0;
      commit = 1'b1; step(); commit = 1'b0;
      found = 0;
      for (int n = 0; n < 2*NFIELD*CONV && !found; n++) begin
         step();
         if ((cyc - 1) % CONV == 0 && ((cyc - 1) / CONV) % NFIELD == 1) found = 1;
      end
      checks++; if (!found) begin failures++; $display("FAIL mid_shift_wait got=timeout exp=field1 LOAD"); end
      repeat (11) step();
      wr_en = 1'b1; wr_addr = 5'd16; wr_data = b; step(); wr_en = 1'b0;
      commit = 1'b1; step(); commit = 1'b0;
      found = 0;
      for (int n = 0; n < CONV && !found; n++) begin
         step();
         if ((cyc - 1) % CONV == 0) found = 1;
      end
      checks++; if (!found || fld(dis_field, 1) !== fmt_field({16'h0, a})) begin failures++; $display("FAIL mid_shift_old got=%s exp=%s", fld(dis_field, 1), fmt_field({16'h0, a})); end
      repeat (NFIELD*CONV) step();
      checks++; if (fld(dis_field, 1) !== fmt_field({16'h0, b})) begin failures++; $display("FAIL mid_shift_new got=%s exp=%s", fld(dis_field, 1), fmt_field({16'h0, b})); end
   endtask

   task automatic test_lzb_format();
      logic [FLD_W-1:0] want0, want305;
`ifdef REG_DECODE_GEN_LZB_EN
      want0 = "       0"; want305 = "     305";
`else
      want0 = "00000000"; want305 = "00000305";
`endif
      ext_val = 32'd0;
      repeat (2*NFIELD*CONV) step();
      checks++; if (fld(dis_field, 0) !== want0) begin failures++; $display("FAIL fmt_zero got=%s exp=%s", fld(dis_field, 0), want0); end
      ext_val = 32'd305;
      repeat (2*NFIELD*CONV) step();
      checks++; if (fld(dis_field, 0) !== want305) begin failures++; $display("FAIL fmt_305 got=%s exp=%s", fld(dis_field, 0), want305); end
   endtask

   task automatic test_random();
      logic [NREG*16-1:0] e_act;
      logic [NCH*4-1:0]   e_gear;
      logic [NCH-1:0]     e_err;
      logic [NCH*80-1:0]  e_str;
      for (int n = 0; n < 900; n++) begin
         wr_en = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 5))
            0: wr_addr = 5'd2;
            1: wr_addr = 5'd3;
            2: wr_addr = 5'd16;
            3: wr_addr = 5'd17;
            4: wr_addr = 5'd18;
            default: wr_addr = 5'($urandom_range(0, NREG - 1));
         endcase
         wr_data = 16'($urandom);
         commit = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 15) == 0) ext_val = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 99999);
         step();
         for (int i = 0; i < NREG; i++) e_act[16*i +: 16] = m_act[i];
         for (int c = 0; c < NCH; c++) begin
            e_gear[4*c +: 4] = m_act[CH_BASE+c][3:0];
            e_err[c] = (m_act[CH_BASE+c][3:0] > 4'd9);
            e_str[80*c +: 80] = gear_exp(c, m_act[CH_BASE+c][3:0]);
         end
         checks++; if (dis_field !== exp_dis) begin failures++; $display("FAIL rnd_dis cyc=%0d got=%h exp=%h", cyc, dis_field, exp_dis); end
         checks++; if (field_valid !== exp_fv) begin failures++; $display("FAIL rnd_fv cyc=%0d got=%b exp=%b", cyc, field_valid, exp_fv); end
         checks++; if (upd !== exp_upd || busy !== 1'b1) begin failures++; $display("FAIL rnd_upd_busy cyc=%0d got=%b%b exp=%b1", cyc, upd, busy, exp_upd); end
         checks++; if (active_regs !== e_act) begin failures++; $display("FAIL rnd_active cyc=%0d got=%h exp=%h", cyc, active_regs, e_act); end
         checks++; if (ch_gear !== e_gear || gear_err !== e_err || ch_gear_str !== e_str) begin failures++; $display("FAIL rnd_gear cyc=%0d got=%h/%b exp=%h/%b", cyc, ch_gear, gear_err, e_gear, e_err); end
      end
      wr_en = 1'b0; commit = 1'b0;
   endtask

   task automatic test_reset_mid_shift();
      bit found = 0;
      logic [31:0] v;
      v = 32'd4321;
      ext_val = v;
      for (int n = 0; n < 2*NFIELD*CONV && !found; n++) begin
         step();
         if ((cyc - 1) % CONV == 15 && ((cyc - 1) / CONV) % NFIELD == 0) found = 1;
      end
      checks++; if (!found) begin failures++; $display("FAIL rst_shift_wait got=timeout exp=SHIFT cycle 15"); end
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (field_valid !== 4'b0000 || dis_field !== exp_dis) begin failures++; $display("FAIL rst_mid_fields got=%b/%h exp=0/all 30", field_valid, dis_field); end
      checks++; if (active_regs !== '0 || ch_gear !== 8'h00 || upd !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_regs got=%h/%h/%b/%b exp=0", active_regs, ch_gear, upd, busy); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (CONV) step();
      checks++; if (field_valid !== 4'b0000 || dis_field !== exp_dis) begin failures++; $display("FAIL rst_no_early_store got=%b exp=0000", field_valid); end
      step();
      checks++; if (field_valid !== 4'b0001 || fld(dis_field, 0) !== fmt_field(v)) begin failures++; $display("FAIL rst_first_store got=%b/%s exp=0001/%s", field_valid, fld(dis_field, 0), fmt_field(v)); end
      checks++; if (dis_field !== exp_dis) begin failures++; $display("FAIL rst_first_model got=%h exp=%h", dis_field, exp_dis); end
   endtask

   initial begin
      test_reset();
      test_field1();
      test_saturation();
      test_gear_same_cycle();
      test_mid_shift();
      test_lzb_format();
      test_random();
      test_reset_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
